// File: rtl/pipeline_ctrl_pkg.sv
// Shared RV32I pipeline types: controller FSM states and the bundled
// per-stage load/flush control word.
package rv32i_types;

  localparam int unsigned REG_W = 5;

  typedef enum logic [0:0] {
    CTRL_RUN  = 1'b0,
    CTRL_WAIT = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_HOLD    = 7'b000_0000;
  localparam pipe_ctrl_t PIPE_RUN     = 7'b111_1100;
  localparam pipe_ctrl_t PIPE_SQUASH  = 7'b111_1111;
  localparam pipe_ctrl_t PIPE_LU_STALL = 7'b001_1101;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Combinational load-use comparator between the ID-stage sources and the
// EX-stage load destination; x0 never creates a hazard.
module load_use_detect
  import rv32i_types::*;
(
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_is_load_i,
  output logic             load_use_o
);

  logic rd_nonzero_s;
  logic hit_rs1_s;
  logic hit_rs2_s;

  assign rd_nonzero_s = (ex_rd_i != 5'd0);
  assign hit_rs1_s    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign hit_rs2_s    = id_use_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use_o   = ex_is_load_i & rd_nonzero_s & (hit_rs1_s | hit_rs2_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory handshake tracking,
// load-use stalls, branch squashes and performance counters.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  output logic             imem_read,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_t      state_q, state_d;
  logic             imem_done_q, imem_done_d;
  logic             dmem_done_q, dmem_done_d;
  logic             active_q;
  logic [CNT_W-1:0] mem_stall_q, mem_stall_d;
  logic [CNT_W-1:0] hazard_q, hazard_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic       i_ok_s, d_ok_s, advance_s, load_use_s, dmem_hit_s;
  pipe_ctrl_t ctrl_s;

  load_use_detect u_load_use (
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .ex_rd_i      (ex_rd),
    .ex_is_load_i (ex_is_load),
    .load_use_o   (load_use_s)
  );

  // A data response only counts when the MEM stage actually issued an access.
  assign dmem_hit_s = dmem_req & dmem_resp;
  assign i_ok_s     = imem_resp | imem_done_q;
  assign d_ok_s     = ~dmem_req | dmem_resp | dmem_done_q;
  assign advance_s  = i_ok_s & d_ok_s;

  // Stage enables; forced to hold while reset is asserted so nothing glitches.
  always_comb begin
    ctrl_s = PIPE_HOLD;
    if (!rst) begin
      ctrl_s = PIPE_HOLD;
    end else if (!advance_s) begin
      ctrl_s = PIPE_HOLD;
    end else if (ex_br_taken) begin
      ctrl_s = PIPE_SQUASH;
    end else if (load_use_s) begin
      ctrl_s = PIPE_LU_STALL;
    end else begin
      ctrl_s = PIPE_RUN;
    end
  end

  assign load_pc     = ctrl_s.load_pc;
  assign load_if_id  = ctrl_s.load_if_id;
  assign load_id_ex  = ctrl_s.load_id_ex;
  assign load_ex_mem = ctrl_s.load_ex_mem;
  assign load_mem_wb = ctrl_s.load_mem_wb;
  assign flush_if_id = ctrl_s.flush_if_id;
  assign flush_id_ex = ctrl_s.flush_id_ex;

  // Next state of the sticky completion bits and the RUN/WAIT FSM.
  always_comb begin
    imem_done_d = imem_done_q;
    dmem_done_d = dmem_done_q;
    state_d     = state_q;
    if (advance_s) begin
      imem_done_d = 1'b0;
      dmem_done_d = 1'b0;
    end else begin
      imem_done_d = imem_done_q | imem_resp;
      dmem_done_d = dmem_done_q | dmem_hit_s;
    end
    case (state_q)
      CTRL_RUN: begin
        if (!advance_s && (imem_resp || dmem_hit_s)) begin
          state_d = CTRL_WAIT;
        end else begin
          state_d = CTRL_RUN;
        end
      end
      CTRL_WAIT: begin
        if (advance_s) begin
          state_d = CTRL_RUN;
        end else begin
          state_d = CTRL_WAIT;
        end
      end
      default: state_d = CTRL_RUN;
    endcase
  end

  // Performance counter next values; wrap naturally at 2^CNT_W.
  always_comb begin
    mem_stall_d = mem_stall_q;
    hazard_d    = hazard_q;
    flush_d     = flush_q;
    if (!advance_s) begin
      mem_stall_d = mem_stall_q + CNT_ONE;
    end else if (ex_br_taken) begin
      flush_d = flush_q + CNT_ONE;
    end else if (load_use_s) begin
      hazard_d = hazard_q + CNT_ONE;
    end else begin
      mem_stall_d = mem_stall_q;
    end
  end

  // Controller state, sticky bits and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CTRL_RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
      active_q    <= 1'b0;
      mem_stall_q <= {CNT_W{1'b0}};
      hazard_q    <= {CNT_W{1'b0}};
      flush_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
      active_q    <= 1'b1;
      mem_stall_q <= mem_stall_d;
      hazard_q    <= hazard_d;
      flush_q     <= flush_d;
    end
  end

  assign imem_read        = active_q & ~imem_done_q;
  assign mem_stall_cnt    = mem_stall_q;
  assign hazard_stall_cnt = hazard_q;
  assign flush_cnt        = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed test-plan scenarios plus
// randomized traffic compared against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_resp, imem_read, dmem_req, dmem_resp;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex;
  logic [31:0] mem_stall_cnt, hazard_stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_idone, m_ddone, m_active;
  logic [31:0] m_mem, m_haz, m_fl;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_resp(imem_resp), .imem_read(imem_read),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mem_stall_cnt(mem_stall_cnt), .hazard_stall_cnt(hazard_stall_cnt),
    .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idone = 1'b0; m_ddone = 1'b0; m_active = 1'b0;
    m_mem = 32'd0; m_haz = 32'd0; m_fl = 32'd0;
  endtask

  function automatic bit model_lu();
    return ex_is_load && ex_rd != 5'd0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit model_adv();
    return (imem_resp || m_idone) && (!dmem_req || dmem_resp || m_ddone);
  endfunction

  // Check every output against the model, then clock one edge and update it.
  task automatic cycle(input string tag);
    logic [4:0] exp_ld;
    logic [1:0] exp_fl;
    #4;
    exp_ld = 5'b00000;
    exp_fl = 2'b00;
    if (rst && model_adv()) begin
      if (ex_br_taken) begin exp_ld = 5'b11111; exp_fl = 2'b11; end
      else if (model_lu()) begin exp_ld = 5'b00111; exp_fl = 2'b01; end
      else exp_ld = 5'b11111;
    end
    chk({tag, ".loads"}, {27'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb},
        {27'd0, exp_ld});
    chk({tag, ".flush"}, {30'd0, flush_if_id, flush_id_ex}, {30'd0, exp_fl});
    chk({tag, ".imem_read"}, {31'd0, imem_read}, {31'd0, rst && m_active && !m_idone});
    chk({tag, ".mem_stall"}, mem_stall_cnt, m_mem);
    chk({tag, ".haz_stall"}, hazard_stall_cnt, m_haz);
    chk({tag, ".flush_cnt"}, flush_cnt, m_fl);
    @(posedge clk);
    if (rst) begin
      if (model_adv()) begin
        if (ex_br_taken) m_fl++;
        else if (model_lu()) m_haz++;
        m_idone = 1'b0;
        m_ddone = 1'b0;
      end else begin
        m_mem++;
        if (imem_resp) m_idone = 1'b1;
        if (dmem_req && dmem_resp) m_ddone = 1'b1;
      end
      m_active = 1'b1;
    end
    #1;
  endtask

  task automatic quiet();
    imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
  endtask

  initial begin
    logic [31:0] base;
    model_reset();
    quiet();
    rst = 1'b0;
    cycle("reset");
    rst = 1'b1;
    cycle("release");

    // Idle, single-cycle memories, no hazards
    for (int i = 0; i < 10; i++) cycle("idle");
    chk("idle.no_stall", mem_stall_cnt, 32'd0);

    // Data access completing three cycles after the fetch
    base = m_mem;
    dmem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      imem_resp = (c == 0);
      dmem_resp = (c == 3);
      cycle("dwait");
    end
    chk("dwait.stall3", mem_stall_cnt - base, 32'd3);
    quiet();
    cycle("dwait.after");

    // Load-use on rs2
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    cycle("lu");
    chk("lu.haz1", hazard_stall_cnt, 32'd1);
    ex_rd = 5'd0; id_rs2 = 5'd0;
    cycle("lu.x0");

    // Branch wins over a simultaneous load-use
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; ex_br_taken = 1'b1;
    cycle("br_lu");
    chk("br_lu.flush1", flush_cnt, 32'd1);
    chk("br_lu.haz_same", hazard_stall_cnt, 32'd1);
    quiet();

    // dmem_resp without a request is ignored
    imem_resp = 1'b0; dmem_resp = 1'b1;
    cycle("stray_dresp");
    quiet();
    cycle("stray_dresp.done");

    // Reset while waiting with imem_done set
    dmem_req = 1'b1; dmem_resp = 1'b0; imem_resp = 1'b1;
    cycle("wait_enter");
    imem_resp = 1'b0;
    cycle("wait_hold");
    rst = 1'b0;
    model_reset();
    imem_resp = 1'b1; dmem_resp = 1'b1;
    #1;
    chk("rst_mid.load_pc", {31'd0, load_pc}, 32'd0);
    chk("rst_mid.imem_read", {31'd0, imem_read}, 32'd0);
    chk("rst_mid.mem_stall", mem_stall_cnt, 32'd0);
    cycle("rst_mid");
    rst = 1'b1;
    quiet();
    cycle("rst_rel");
    cycle("rst_rel2");

    // Randomized traffic with a small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      imem_resp   = ($urandom_range(0, 3) != 0);
      if (!dmem_req || !(dmem_resp || m_ddone) || model_adv())
        dmem_req  = ($urandom_range(0, 1) == 1);
      dmem_resp   = ($urandom_range(0, 2) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = ($urandom_range(0, 1) == 1);
      id_use_rs2  = ($urandom_range(0, 1) == 1);
      ex_is_load  = ($urandom_range(0, 1) == 1);
      ex_br_taken = ($urandom_range(0, 5) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. Every cycle it decides whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers load, hold or take a bubble. It tracks outstanding instruction- and data-memory handshakes with sticky completion flags, detects load-use hazards between ID and EX, and squashes wrong-path instructions on a taken branch or jump. It also keeps free-running performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- imem_resp  in  1  instruction memory returned fetch data this cycle
- imem_read  out  1  instruction fetch request
- dmem_req  in  1  MEM-stage instruction is a load/store (stable while stalled)
- dmem_resp  in  1  data memory completed the MEM-stage access this cycle
- id_rs1, id_rs2  in  5 each  ID-stage source registers
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2
- ex_rd  in  5  EX-stage destination register
- ex_is_load  in  1  EX-stage instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch or jump (redirect)
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage-register load enables
- flush_if_id, flush_id_ex  out  1 each  load a NOP/bubble instead of the upstream value
- mem_stall_cnt, hazard_stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- State: `imem_done` and `dmem_done` sticky bits, plus an FSM of two states.
  - CTRL_RUN: both sticky bits clear.
  - CTRL_WAIT: at least one sticky bit set.
  - RUN→WAIT when exactly one memory completes without an advance. WAIT→RUN on advance.
- `i_ok = imem_resp | imem_done`
- `d_ok = !dmem_req | dmem_resp | dmem_done`
- `advance = i_ok & d_ok`
- If `!advance`, the PC and all buffer load enables are 0 and the flushes are 0.
  - `imem_resp` sets `imem_done`.
  - `dmem_resp` sets `dmem_done`.
- On advance, both sticky bits clear.
- `imem_read = !imem_done` outside reset.
  - A completed fetch is never re-requested while the pipeline waits on data memory.
- `load_use = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`
- Priority on advance (first match wins):
  1. `ex_br_taken`: all loads = 1, `flush_if_id = flush_id_ex = 1`, `flush_cnt++`.
  2. `load_use`: `load_pc = load_if_id = 0`, `load_id_ex = load_ex_mem = load_mem_wb = 1`, `flush_id_ex = 1`, `hazard_stall_cnt++`.
  3. Otherwise: all loads = 1, no flush.
- `mem_stall_cnt` increments on every cycle with `!advance`, outside reset.
- All counters wrap modulo 2^CNT_W.

## Timing
- Reset (`rst` low, asynchronous): every output is 0, including `imem_read` and all counters. Sticky bits clear. FSM enters CTRL_RUN.
- First rising edge after `rst` rises: `imem_read = 1`.
- Load/flush outputs are combinational from `imem_resp`, `dmem_resp`, hazard and branch inputs, with zero-cycle latency. Stage registers capture on the same edge.
- Sticky bits and counters update on the rising clk edge.
- `imem_resp` and `dmem_resp` in the same cycle count as an advance; no state is entered.
- A `dmem_resp` while `dmem_req = 0` is ignored and sets no bit.
- Branch plus load-use in the same cycle: the branch wins. The younger load-use is squashed.
- Reset asserted mid-WAIT discards the sticky bits and the pending handshake. No enable glitches to 1 during reset.

## Structure
- `rv32i_types` gains:
  - `ctrl_state_t` enum {CTRL_RUN, CTRL_WAIT}
  - `pipe_ctrl_t` packed struct bundling the five loads and two flushes, so stages take one port
- Sub-module `load_use_detect`: purely combinational comparator (rs1/rs2/use bits vs ex_rd/ex_is_load → `load_use`). It is reused by the future forwarding unit.
- The counters stay in `pipeline_ctrl`.

## Test plan
- Reset then idle, all memory responding in 1 cycle with no hazards: all loads = 1 every cycle. `mem_stall_cnt` stays 0 after 10 cycles.
- `dmem_req = 1`, `imem_resp` at cycle 0, `dmem_resp` at cycle 3:
  - `imem_read` falls at cycle 1.
  - Loads are 0 for cycles 0–2 and go to 1 at cycle 3.
  - `mem_stall_cnt = 3`.
  - The FSM returns to RUN.
- `ex_is_load = 1`, `ex_rd = 5`, `id_rs2 = 5`, `id_use_rs2 = 1`, memories ready: `load_pc = load_if_id = 0`, `flush_id_ex = 1`, `hazard_stall_cnt = 1`.
- Same as the previous case but `ex_rd = 0`: no stall. All loads = 1.
- `ex_br_taken = 1` together with a load-use condition: both flushes = 1, `load_pc = 1`, `flush_cnt = 1`, `hazard_stall_cnt` unchanged.
- Pull `rst` low while `imem_done = 1` in WAIT: all outputs 0 immediately. After release, `imem_read = 1` and the FSM is in RUN.
